led_display_mode_scheduler: RTL and testbench

//  Drives mode_in of the LED display pattern generator.
//  - Selects the mode from a manual request, or auto-cycles through a mask of enabled modes

---
 rtl/led_display_mode_scheduler.sv | 122 ++++++++++++
 tb/tb_led_display_mode_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_display_mode_scheduler.sv
// Mode scheduler for the LED pattern generator: manual or auto-cycled mode selection,
// committed only on frame boundaries, with a watchdog that forces a stalled commit.
module led_display_mode_scheduler #(
  parameter int NUM_ROW_ADDR    = 16,
  parameter int MODE_W          = 4,
  parameter int DWELL_FRAMES    = 60,
  parameter int WATCHDOG_CYCLES = 1_000_000,
  parameter int SIMULATION      = 0
) (
  input  logic                   clk_in,
  input  logic                   n_reset_in,
  input  logic [MODE_W-1:0]      manual_mode_in,
  input  logic                   auto_en_in,
  input  logic [2**MODE_W-1:0]   auto_mask_in,
  input  logic                   row_valid_in,
  input  logic                   row_ready_in,
  input  logic [3:0]             row_address_in,
  output logic [MODE_W-1:0]      mode_out,
  output logic                   mode_change_out,
  output logic [15:0]            frame_count_out,
  output logic                   watchdog_out
);
  localparam int NUM_MODES = 2**MODE_W;
  localparam int DWELL     = (SIMULATION != 0) ? 2  : DWELL_FRAMES;
  localparam int WD_LIM    = (SIMULATION != 0) ? 64 : WATCHDOG_CYCLES;
  localparam int DW_W      = $clog2(DWELL + 1);
  localparam int WD_W      = $clog2(WD_LIM + 1);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROW_ADDR - 1);

  typedef enum logic [1:0] {MANUAL, AUTO, PENDING} state_t;

  state_t            state, state_nxt;
  logic [DW_W-1:0]   dwell, dwell_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              fe, commit, wd_fire, changing;
  logic [MODE_W-1:0] commit_mode, next_auto;

  assign fe = row_valid_in & row_ready_in & (row_address_in == LAST_ROW);

  // Walk downward so the closest enabled mode above mode_out wins; the
  // i == NUM_MODES step wraps back to mode_out itself, and an empty mask yields 0.
  always_comb begin
    next_auto = '0;
    for (int i = NUM_MODES; i >= 1; i--) begin
      if (auto_mask_in[mode_out + MODE_W'(i)]) next_auto = mode_out + MODE_W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell;
    wd_cnt_nxt  = wd_cnt;
    commit      = 1'b0;
    commit_mode = mode_out;
    wd_fire     = 1'b0;
    unique case (state)
      MANUAL: begin
        if (auto_en_in) begin
          state_nxt = AUTO;
          dwell_nxt = '0;
        end else if (manual_mode_in != mode_out) begin
          state_nxt  = PENDING;
          wd_cnt_nxt = '0;
        end
      end
      AUTO: begin
        // Dropping auto_en beats a same-cycle dwell expiry.
        if (!auto_en_in) begin
          state_nxt = MANUAL;
        end else if (fe) begin
          if (dwell == DW_W'(DWELL - 1)) begin
            dwell_nxt   = '0;
            commit      = 1'b1;
            commit_mode = next_auto;
          end else begin
            dwell_nxt = dwell + DW_W'(1);
          end
        end
      end
      PENDING: begin
        commit_mode = manual_mode_in;
        if (manual_mode_in == mode_out) begin
          state_nxt = MANUAL;
        end else if (fe || wd_cnt == WD_W'(WD_LIM - 1)) begin
          commit    = 1'b1;
          wd_fire   = ~fe;
          state_nxt = MANUAL;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      default: state_nxt = MANUAL;
    endcase
  end

  // A commit that lands on the current mode (auto search wrapped) restarts dwell silently.
  assign changing = commit & (commit_mode != mode_out);

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state           <= MANUAL;
      dwell           <= '0;
      wd_cnt          <= '0;
      mode_out        <= '0;
      mode_change_out <= 1'b0;
      frame_count_out <= '0;
      watchdog_out    <= 1'b0;
    end else begin
      state           <= state_nxt;
      dwell           <= dwell_nxt;
      wd_cnt          <= wd_cnt_nxt;
      mode_change_out <= changing;
      if (changing) begin
        mode_out        <= commit_mode;
        frame_count_out <= '0;
      end else if (fe && frame_count_out != 16'hFFFF) begin
        frame_count_out <= frame_count_out + 16'd1;
      end
      if (wd_fire) watchdog_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_led_display_mode_scheduler.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_led_display_mode_scheduler;
  localparam int NM = 16;
  localparam int DW = 2;
  localparam int WD = 64;

  logic        clk_in = 1'b0;
  logic        n_reset_in = 1'b0;
  logic [3:0]  manual_mode_in = '0;
  logic        auto_en_in = 1'b0;
  logic [15:0] auto_mask_in = '0;
  logic        row_valid_in = 1'b0;
  logic        row_ready_in = 1'b0;
  logic [3:0]  row_address_in = '0;
  logic [3:0]  mode_out;
  logic        mode_change_out;
  logic [15:0] frame_count_out;
  logic        watchdog_out;

  always #5 clk_in = ~clk_in;

  led_display_mode_scheduler #(.NUM_ROW_ADDR(16), .MODE_W(4), .DWELL_FRAMES(60),
                               .WATCHDOG_CYCLES(1_000_000), .SIMULATION(1)) dut (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .manual_mode_in(manual_mode_in),
    .auto_en_in(auto_en_in), .auto_mask_in(auto_mask_in), .row_valid_in(row_valid_in),
    .row_ready_in(row_ready_in), .row_address_in(row_address_in), .mode_out(mode_out),
    .mode_change_out(mode_change_out), .frame_count_out(frame_count_out),
    .watchdog_out(watchdog_out));

  typedef struct { int mode; bit chg; int fc; bit wdg; } exp_t;
  exp_t sb_q[$];
  int   n_vec = 0, n_bad = 0;

  // Reference model: what the scheduler is doing, in plain terms.
  int   m_mode, m_fc, m_dwell, m_stall;
  bit   m_chg, m_wdg, m_auto, m_pend;
  logic [3:0] addr_q = '0;

  function automatic int next_enabled(input int cur, input logic [15:0] mask);
    for (int k = 1; k <= NM; k++) if (mask[(cur + k) % NM]) return (cur + k) % NM;
    return 0;
  endfunction

  function void model_reset();
    m_mode = 0; m_fc = 0; m_chg = 0; m_wdg = 0;
    m_auto = 0; m_pend = 0; m_dwell = 0; m_stall = 0;
  endfunction

  function void model_step();
    bit fe;
    int man, tgt;
    fe  = row_valid_in && row_ready_in && (row_address_in == 4'd15);
    man = int'(manual_mode_in);
    tgt = m_mode;
    if (m_pend) begin
      if (man == m_mode) m_pend = 0;
      else if (fe) begin tgt = man; m_pend = 0; end
      else if (m_stall == WD - 1) begin tgt = man; m_pend = 0; m_wdg = 1; end
      else m_stall++;
    end else if (m_auto) begin
      if (!auto_en_in) m_auto = 0;
      else if (fe) begin
        if (m_dwell == DW - 1) begin m_dwell = 0; tgt = next_enabled(m_mode, auto_mask_in); end
        else m_dwell++;
      end
    end else begin
      if (auto_en_in) begin m_auto = 1; m_dwell = 0; end
      else if (man != m_mode) begin m_pend = 1; m_stall = 0; end
    end
    m_chg = (tgt != m_mode);
    if (m_chg) m_fc = 0;
    else if (fe && m_fc < 65535) m_fc++;
    m_mode = tgt;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.mode = m_mode; e.chg = m_chg; e.fc = m_fc; e.wdg = m_wdg;
    return e;
  endfunction

  task automatic tick(input int man, input bit aen, input logic [15:0] mask,
                      input bit vld, input bit rdy);
    @(posedge clk_in); #1;
    sb_q.push_back(snap());
    manual_mode_in = 4'(man); auto_en_in = aen; auto_mask_in = mask;
    row_valid_in = vld; row_ready_in = rdy; row_address_in = addr_q;
    if (n_reset_in) model_step();
    if (vld && rdy) addr_q = addr_q + 4'd1;
  endtask

  task automatic stream(input int n, input int man, input bit aen, input logic [15:0] mask,
                        input int vld_pct, input int rdy_pct);
    repeat (n) tick(man, aen, mask, int'($urandom_range(99)) < vld_pct,
                    int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic release_reset();
    @(posedge clk_in); #1;
    sb_q.push_back(snap());
    n_reset_in = 1'b1;
    model_step();
  endtask

  // Asserted between edges so the reset values can only appear asynchronously.
  task automatic reset_async(input int cycles);
    @(posedge clk_in); #2;
    n_reset_in = 1'b0; row_valid_in = 1'b0;
    model_reset();
    sb_q.push_back(snap());
    repeat (cycles) tick(int'(manual_mode_in), auto_en_in, auto_mask_in, 0, 0);
    release_reset();
  endtask

  task automatic drop_on_expiry(input logic [15:0] mask);
    for (int i = 0; i < 200; i++) begin
      if (m_auto && m_dwell == DW - 1 && addr_q == 4'd15) begin
        tick(m_mode, 0, mask, 1, 1);
        break;
      end
      tick(m_mode, 1, mask, 1, 1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (mode_out !== 4'(e.mode) || mode_change_out !== e.chg ||
            frame_count_out !== 16'(e.fc) || watchdog_out !== e.wdg) begin
          n_bad++;
          $display("FAIL outputs @%0t: got mode=%0d chg=%0b fc=%0d wd=%0b, want mode=%0d chg=%0b fc=%0d wd=%0b",
                   $time, mode_out, mode_change_out, frame_count_out, watchdog_out,
                   e.mode, e.chg, e.fc, e.wdg);
        end
      end
    end
  end

  initial begin : stim
    int man, len, rdy_pct;
    bit aen;
    logic [15:0] mask;
    model_reset();
    manual_mode_in = 4'd2;
    repeat (3) tick(2, 0, 16'h0, 0, 0);
    release_reset();
    // manual request committed at the first frame end
    stream(40, 2, 0, 16'h0, 100, 100);
    // auto cycle 1,4,5,6,1
    stream(200, 2, 1, 16'h0072, 100, 100);
    // manual 3, then 5 under a stalled PHY -> watchdog
    stream(40, 3, 0, 16'h0, 100, 100);
    stream(100, 5, 0, 16'h0, 100, 0);
    stream(30, 5, 0, 16'h0, 100, 100);
    // toggle away and back before any frame end
    stream(40, 3, 0, 16'h0, 100, 100);
    tick(5, 0, 16'h0, 1, 0);
    tick(3, 0, 16'h0, 1, 0);
    stream(10, 3, 0, 16'h0, 100, 0);
    // auto_en drops on the dwell-expiry frame end
    stream(5, 3, 1, 16'h0072, 100, 100);
    drop_on_expiry(16'h0072);
    stream(40, m_mode, 0, 16'h0072, 100, 100);
    // reset while a change is pending
    stream(5, 7, 0, 16'h0, 100, 0);
    reset_async(3);
    stream(40, 7, 0, 16'h0, 100, 100);
    // boundary masks: empty and only-current-mode
    stream(80, 7, 1, 16'h0, 100, 100);
    stream(80, 7, 1, 16'h0001, 100, 100);
    for (int ph = 0; ph < 80; ph++) begin
      man = int'($urandom_range(15));
      aen = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0:       mask = 16'h0;
        1:       mask = 16'h1 << m_mode;
        default: mask = 16'($urandom);
      endcase
      len     = int'($urandom_range(120, 10));
      rdy_pct = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(100, 50));
      if ($urandom_range(7) == 0) addr_q = 4'($urandom_range(15));
      stream(len, man, aen, mask, 90, rdy_pct);
      if ($urandom_range(15) == 0) reset_async(2);
    end
    @(posedge clk_in); #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
